// File: rtl/mem_access.sv
// mem_access: pipeline memory stage between EX and WB.
// ALU results pass through in one cycle. Aligned loads and stores go out on a
// single-request data-memory port and wait for an acknowledge or a timeout.
// Misaligned accesses and bus timeouts come back as flagged write-back pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a new EX result; ALU ops and misaligned ops retire here
// ACCESS | dm_req held high, waiting for dm_ack or the timeout count
module mem_access #(
  parameter int DM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_reg_addr,
  input  logic        ex_reg_write,
  input  logic [3:0]  ex_mem_op,
  input  logic        ex_mem_unsigned,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_addr,
  output logic        wb_reg_write,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_code,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Counter only ever needs to hold DM_TIMEOUT-1; the +1 keeps a legal width
  // when DM_TIMEOUT is 1.
  localparam int              CNT_W   = $clog2(DM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DM_TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  // Access parameters captured at accept, used when the access completes
  logic       op_store;
  logic [1:0] op_size;
  logic       op_unsigned;
  logic [1:0] op_addr_lo;
  logic [4:0] op_reg_addr;
  logic       op_reg_write;

  logic       accept;
  logic       is_mem;
  logic       is_store;
  logic [1:0] size;
  logic       misaligned;
  logic       start_access;
  logic       ack_done;
  logic       timeout_hit;

  // Byte enables for a store of the given size at the given byte offset
  function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] s;
    case (sz)
      SZ_BYTE: s = 4'b0001 << lo;
      SZ_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate store data across lanes so the strobes alone pick the target bytes
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of the read word and extend it to 32 bits
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] lo,
                                               input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Decode of the incoming EX result and of the ACCESS exit conditions
  always_comb begin
    ex_ready     = (state == S_IDLE);
    accept       = ex_valid & ex_ready;
    is_mem       = ex_mem_op[3];
    is_store     = ex_mem_op[2];
    size         = ex_mem_op[1:0];
    // Size 11 is treated as a word, so size[1] alone means "word"
    misaligned   = ((size == SZ_HALF) & ex_res[0]) | (size[1] & (ex_res[1:0] != 2'b00));
    start_access = accept & is_mem & ~misaligned;
    ack_done     = (state == S_ACCESS) & dm_ack;
    // Ack in the final cycle wins, so timeout requires no ack
    timeout_hit  = (state == S_ACCESS) & ~dm_ack & (cnt == CNT_LAST);
  end

  // FSM and access timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_access) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (ack_done || timeout_hit) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Capture the parts of the op needed at completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_store     <= 1'b0;
      op_size      <= 2'b00;
      op_unsigned  <= 1'b0;
      op_addr_lo   <= 2'b00;
      op_reg_addr  <= 5'd0;
      op_reg_write <= 1'b0;
    end else if (start_access) begin
      op_store     <= is_store;
      op_size      <= size;
      op_unsigned  <= ex_mem_unsigned;
      op_addr_lo   <= ex_res[1:0];
      op_reg_addr  <= ex_reg_addr;
      op_reg_write <= ex_reg_write;
    end
  end

  // Data-memory port: request fields stay frozen for the whole ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_wdata <= 32'h0;
      dm_wstrb <= 4'b0000;
    end else if (start_access) begin
      dm_req   <= 1'b1;
      dm_we    <= is_store;
      dm_addr  <= {ex_res[31:2], 2'b00};
      dm_wdata <= is_store ? store_lanes(size, ex_store_data) : 32'h0;
      dm_wstrb <= is_store ? store_strobe(size, ex_res[1:0]) : 4'b0000;
    end else if (ack_done || timeout_hit) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_wstrb <= 4'b0000;
    end
  end

  // Write-back pulse; enables and exception flags last only for the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_data      <= 32'h0;
      wb_reg_addr  <= 5'd0;
      wb_reg_write <= 1'b0;
      mem_exc      <= 1'b0;
      mem_exc_code <= EXC_NONE;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_exc      <= 1'b0;
      mem_exc_code <= EXC_NONE;
      if (accept && !is_mem) begin
        wb_valid     <= 1'b1;
        wb_data      <= ex_res;
        wb_reg_addr  <= ex_reg_addr;
        wb_reg_write <= ex_reg_write;
      end else if (accept && misaligned) begin
        wb_valid     <= 1'b1;
        wb_data      <= 32'h0;
        wb_reg_addr  <= ex_reg_addr;
        mem_exc      <= 1'b1;
        mem_exc_code <= EXC_MISALIGN;
      end else if (ack_done) begin
        wb_valid     <= 1'b1;
        wb_data      <= op_store ? 32'h0
                                 : load_extract(op_size, op_addr_lo, op_unsigned, dm_rdata);
        wb_reg_addr  <= op_reg_addr;
        wb_reg_write <= op_store ? 1'b0 : op_reg_write;
      end else if (timeout_hit) begin
        wb_valid     <= 1'b1;
        wb_data      <= 32'h0;
        wb_reg_addr  <= op_reg_addr;
        mem_exc      <= 1'b1;
        mem_exc_code <= EXC_TIMEOUT;
      end
    end
  end

endmodule
